// File: rtl/irrigation_scheduler_pkg.sv
// rtl/irrigation_scheduler_pkg.sv - shared state, fault and level-code encodings
package irrigation_scheduler_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SPRINKLER = 3'd1,
      ST_DRIPPER   = 3'd2,
      ST_SETTLE    = 3'd3,
      ST_FAULT     = 3'd4
   } state_t;

   localparam logic [1:0] FAULT_NONE     = 2'b00;
   localparam logic [1:0] FAULT_CRITICAL = 2'b01;
   localparam logic [1:0] FAULT_SENSOR   = 2'b10;

   // Level probe codes ordered {high, mid, low}; only thermometer patterns are physical.
   localparam logic [2:0] LEVEL_EMPTY = 3'b000;
   localparam logic [2:0] LEVEL_LOW   = 3'b001;
   localparam logic [2:0] LEVEL_MID   = 3'b011;
   localparam logic [2:0] LEVEL_FULL  = 3'b111;

   function automatic logic level_valid(input logic [2:0] code);
      return (code == LEVEL_EMPTY) || (code == LEVEL_LOW) ||
             (code == LEVEL_MID)   || (code == LEVEL_FULL);
   endfunction

endpackage

// File: rtl/irrigation_selector.sv
// rtl/irrigation_selector.sv - combinational sprinkler/dripper mode choice
module irrigation_selector (
   input  logic air_humidity,
   input  logic low_temperature,
   input  logic probe_mid,
   output logic sprinkler_sel
);

   // Sprinkle in dry air, or in warm weather when the tank is at least half full.
   always_comb begin
      sprinkler_sel = !air_humidity || (probe_mid && !low_temperature);
   end

endmodule

// File: rtl/water_level_checker.sv
// rtl/water_level_checker.sv - decodes level probes into sensor error and critical level
module water_level_checker
   import irrigation_scheduler_pkg::*;
(
   input  logic probe_low,
   input  logic probe_mid,
   input  logic probe_high,
   output logic sensor_err,
   output logic critical
);

   logic [2:0] code;

   assign code = {probe_high, probe_mid, probe_low};

   // A non-thermometer code means a stuck or miswired probe; a dry low probe on a sane code is critical.
   always_comb begin
      sensor_err = !level_valid(code);
      critical   = level_valid(code) && !probe_low;
   end

endmodule

// File: rtl/irrigation_scheduler.sv
// rtl/irrigation_scheduler.sv - valve sequencing FSM with min on-time, dead time and fault recovery
module irrigation_scheduler
   import irrigation_scheduler_pkg::*;
#(
   parameter int TIMER_W        = 16,
   parameter int MIN_ON_CYCLES  = 8,
   parameter int DEAD_CYCLES    = 4,
   parameter int RECOVER_CYCLES = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       soil_dry,
   input  logic       air_humidity,
   input  logic       low_temperature,
   input  logic       probe_low,
   input  logic       probe_mid,
   input  logic       probe_high,
   output logic       sprinkler_valve,
   output logic       dripper_valve,
   output logic [1:0] fault_code,
   output logic [2:0] state
);

   localparam logic [TIMER_W-1:0] MIN_ON_LIMIT  = TIMER_W'(MIN_ON_CYCLES - 1);
   localparam logic [TIMER_W-1:0] DEAD_LIMIT    = TIMER_W'(DEAD_CYCLES - 1);
   localparam logic [TIMER_W-1:0] RECOVER_LIMIT = TIMER_W'(RECOVER_CYCLES - 1);

   state_t             cur_state;
   state_t             next_state;
   logic [TIMER_W-1:0] timer;
   logic               sensor_err;
   logic               critical;
   logic               fault_any;
   logic               sprinkler_sel;

   water_level_checker u_level (
      .probe_low  (probe_low),
      .probe_mid  (probe_mid),
      .probe_high (probe_high),
      .sensor_err (sensor_err),
      .critical   (critical)
   );

   irrigation_selector u_selector (
      .air_humidity    (air_humidity),
      .low_temperature (low_temperature),
      .probe_mid       (probe_mid),
      .sprinkler_sel   (sprinkler_sel)
   );

   assign fault_any = sensor_err || critical;
   assign state     = cur_state;

   // Next-state selection: a fault preempts everything, including the minimum on-time.
   always_comb begin
      next_state = cur_state;
      if (fault_any) begin
         next_state = ST_FAULT;
      end else begin
         case (cur_state)
            ST_IDLE:
               if (soil_dry) next_state = sprinkler_sel ? ST_SPRINKLER : ST_DRIPPER;
            ST_SPRINKLER:
               if (timer >= MIN_ON_LIMIT && (!soil_dry || !sprinkler_sel)) next_state = ST_SETTLE;
            ST_DRIPPER:
               if (timer >= MIN_ON_LIMIT && (!soil_dry || sprinkler_sel)) next_state = ST_SETTLE;
            ST_SETTLE:
               if (timer >= DEAD_LIMIT) next_state = ST_IDLE;
            ST_FAULT:
               if (timer >= RECOVER_LIMIT) next_state = ST_SETTLE;
            default:
               next_state = ST_FAULT;
         endcase
      end
   end

   // State, timer and registered Moore outputs; in FAULT the timer counts only clean cycles.
   always_ff @(posedge clock) begin
      if (reset) begin
         cur_state       <= ST_IDLE;
         timer           <= '0;
         sprinkler_valve <= 1'b0;
         dripper_valve   <= 1'b0;
         fault_code      <= FAULT_NONE;
      end else begin
         cur_state <= next_state;
         if (next_state != cur_state || (cur_state == ST_FAULT && fault_any)) begin
            timer <= '0;
         end else if (timer != '1) begin
            timer <= timer + 1'b1;
         end
         sprinkler_valve <= (next_state == ST_SPRINKLER);
         dripper_valve   <= (next_state == ST_DRIPPER);
         if (sensor_err)    fault_code <= FAULT_SENSOR;
         else if (critical) fault_code <= FAULT_CRITICAL;
         else               fault_code <= FAULT_NONE;
      end
   end

endmodule

// File: tb/tb_irrigation_scheduler.sv
// tb/tb_irrigation_scheduler.sv - directed self-checking bench for irrigation_scheduler
module tb_irrigation_scheduler;
   import irrigation_scheduler_pkg::*;

   logic       clock = 1'b0;
   logic       reset;
   logic       soil_dry;
   logic       air_humidity;
   logic       low_temperature;
   logic       probe_low;
   logic       probe_mid;
   logic       probe_high;
   logic       sprinkler_valve;
   logic       dripper_valve;
   logic [1:0] fault_code;
   logic [2:0] state;

   int total = 0;
   int bad   = 0;

   irrigation_scheduler dut (
      .clock           (clock),
      .reset           (reset),
      .soil_dry        (soil_dry),
      .air_humidity    (air_humidity),
      .low_temperature (low_temperature),
      .probe_low       (probe_low),
      .probe_mid       (probe_mid),
      .probe_high      (probe_high),
      .sprinkler_valve (sprinkler_valve),
      .dripper_valve   (dripper_valve),
      .fault_code      (fault_code),
      .state           (state)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_probes(input logic [2:0] p);
      {probe_high, probe_mid, probe_low} = p;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic chk_out(input string tag, input logic [2:0] st, input logic spr, input logic drp,
                          input logic [1:0] fc);
      chk({tag, "_state"}, 16'(state), 16'(st));
      chk({tag, "_spr"}, 16'(sprinkler_valve), 16'(spr));
      chk({tag, "_drp"}, 16'(dripper_valve), 16'(drp));
      chk({tag, "_fc"}, 16'(fault_code), 16'(fc));
   endtask

   initial begin
      reset = 1'b1;
      soil_dry = 1'b0;
      air_humidity = 1'b0;
      low_temperature = 1'b0;
      set_probes(3'b000);
      step();
      step();
      chk_out("reset", 3'd0, 1'b0, 1'b0, 2'b00);
      chk("reset_timer", dut.timer, 16'd0);

      // 1: dry air with full tank -> sprinkler one edge after demand
      reset = 1'b0;
      set_probes(3'b111);
      soil_dry = 1'b1;
      step();
      chk_out("t1_open", 3'd1, 1'b1, 1'b0, 2'b00);

      // 2: humid and cold -> dripper, demand withdrawn early, still 8 cycles open
      do_reset();
      air_humidity = 1'b1;
      low_temperature = 1'b1;
      soil_dry = 1'b1;
      step();
      chk_out("t2_open", 3'd2, 1'b0, 1'b1, 2'b00);
      for (int i = 1; i < 8; i++) begin
         step();
         chk("t2_hold", 16'(dripper_valve), 16'd1);
         if (i == 1) soil_dry = 1'b0;
      end
      step();
      chk_out("t2_settle", 3'd3, 1'b0, 1'b0, 2'b00);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t2_settle_hold", 16'(state), 16'd3);
      end
      step();
      chk("t2_idle", 16'(state), 16'd0);

      // 3: sprinkler, brief mode flip ignored, later flip switches via settle/idle
      do_reset();
      air_humidity = 1'b0;
      low_temperature = 1'b0;
      soil_dry = 1'b1;
      step();
      chk("t3_open", 16'(sprinkler_valve), 16'd1);
      step();
      air_humidity = 1'b1;
      low_temperature = 1'b1;
      step();
      chk("t3_flip_a", 16'(sprinkler_valve), 16'd1);
      step();
      chk("t3_flip_b", 16'(sprinkler_valve), 16'd1);
      air_humidity = 1'b0;
      low_temperature = 1'b0;
      for (int i = 4; i < 10; i++) begin
         step();
         chk("t3_hold", 16'(state), 16'd1);
      end
      air_humidity = 1'b1;
      low_temperature = 1'b1;
      step();
      chk_out("t3_settle", 3'd3, 1'b0, 1'b0, 2'b00);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t3_settle_hold", 16'(state), 16'd3);
         chk("t3_never_both", 16'(sprinkler_valve & dripper_valve), 16'd0);
      end
      step();
      chk_out("t3_idle", 3'd0, 1'b0, 1'b0, 2'b00);
      step();
      chk_out("t3_drip", 3'd2, 1'b0, 1'b1, 2'b00);

      // 4: critical level during dripper on-time, interrupted and then clean recovery
      do_reset();
      step();
      chk("t4_open", 16'(dripper_valve), 16'd1);
      step();
      set_probes(3'b000);
      step();
      chk_out("t4_fault", 3'd4, 1'b0, 1'b0, 2'b01);
      set_probes(3'b111);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t4_partial", 16'(state), 16'd4);
      end
      chk("t4_partial_fc", 16'(fault_code), 16'd0);
      set_probes(3'b000);
      step();
      chk_out("t4_refault", 3'd4, 1'b0, 1'b0, 2'b01);
      chk("t4_refault_timer", dut.timer, 16'd0);
      set_probes(3'b111);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t4_recover_wait", 16'(state), 16'd4);
      end
      step();
      chk_out("t4_settle", 3'd3, 1'b0, 1'b0, 2'b00);
      soil_dry = 1'b0;
      for (int i = 0; i < 3; i++) step();
      chk("t4_settle_end", 16'(state), 16'd3);
      step();
      chk("t4_idle", 16'(state), 16'd0);

      // 5: non-thermometer probe code, then an illegal state loaded by force
      do_reset();
      set_probes(3'b101);
      step();
      chk_out("t5_sensor", 3'd4, 1'b0, 1'b0, 2'b10);
      set_probes(3'b111);
      for (int i = 0; i < 4; i++) step();
      chk("t5_recover", 16'(state), 16'd3);
      for (int i = 0; i < 4; i++) step();
      chk("t5_idle", 16'(state), 16'd0);
      force dut.cur_state = state_t'(3'd5);
      #2;
      release dut.cur_state;
      step();
      chk_out("t5_illegal", 3'd4, 1'b0, 1'b0, 2'b00);

      // 6: reset while sprinkler is open mid on-time
      do_reset();
      air_humidity = 1'b0;
      low_temperature = 1'b0;
      soil_dry = 1'b1;
      step();
      for (int i = 0; i < 5; i++) step();
      chk("t6_timer5", dut.timer, 16'd5);
      chk("t6_open", 16'(sprinkler_valve), 16'd1);
      reset = 1'b1;
      step();
      chk_out("t6_reset", 3'd0, 1'b0, 1'b0, 2'b00);
      chk("t6_timer0", dut.timer, 16'd0);
      reset = 1'b0;
      step();
      chk_out("t6_reopen", 3'd1, 1'b1, 1'b0, 2'b00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
